// File: rtl/ram_access_ctrl_if.sv
// Request/response handshake bundle between a single master and ram_access_ctrl.
// The master drives requests and resp_ready; the controller (slave) drives the rest.
interface ram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_write;
  logic [DATA_WIDTH-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_write, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_write, resp_rdata
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Single-outstanding access controller driving the banked RAM array strobes and data bus.
// Define RAM_TURNAROUND_EN to insert a dead bus (TURN) cycle between WR and RESP.
//
// state | meaning
// IDLE  | req_ready=1, strobes low, bus released
// WR    | one cycle: cs+we, controller drives wdata
// RD    | READ_LATENCY cycles: cs+oe, data sampled on last edge
// TURN  | optional dead cycle after WR, all strobes low
// RESP  | resp_valid held until resp_ready
module ram_access_ctrl #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ram_access_ctrl_if.slave      s_bus,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  inout  wire  [DATA_WIDTH-1:0] io_ram_data,
  output logic                  o_ram_cs,
  output logic                  o_ram_we,
  output logic                  o_ram_oe
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_RD   = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
`ifdef RAM_TURNAROUND_EN
  localparam logic [2:0] ST_TURN = 3'd4;
`endif
  localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

  logic [2:0]            r_state;
  logic [2:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic                  r_ram_cs;
  logic                  r_ram_we;
  logic                  r_ram_oe;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_write;
  logic [DATA_WIDTH-1:0] r_resp_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_wdata      <= '0;
      r_ram_addr   <= '0;
      r_ram_cs     <= 1'b0;
      r_ram_we     <= 1'b0;
      r_ram_oe     <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_write <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_ram_addr  <= s_bus.req_addr;
            r_wdata     <= s_bus.req_wdata;
            r_ram_cs    <= 1'b1;
            if (s_bus.req_we) begin
              r_state  <= ST_WR;
              r_ram_we <= 1'b1;
            end else begin
              r_state  <= ST_RD;
              r_ram_oe <= 1'b1;
              r_cnt    <= '0;
            end
          end
        end
        ST_WR: begin
          r_ram_cs <= 1'b0;
          r_ram_we <= 1'b0;
`ifdef RAM_TURNAROUND_EN
          r_state  <= ST_TURN;
        end
        ST_TURN: begin
`endif
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_write <= 1'b1;
          r_resp_rdata <= '0;
        end
        ST_RD: begin
          if (r_cnt == CNT_LAST) begin
            r_state      <= ST_RESP;
            r_ram_cs     <= 1'b0;
            r_ram_oe     <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_write <= 1'b0;
            r_resp_rdata <= io_ram_data;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        ST_RESP: begin
          if (s_bus.resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_ram_cs     <= 1'b0;
          r_ram_we     <= 1'b0;
          r_ram_oe     <= 1'b0;
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  // The bus is driven exactly while write_enable is asserted, never otherwise.
  assign io_ram_data = r_ram_we ? r_wdata : {DATA_WIDTH{1'bz}};

  assign o_ram_addr       = r_ram_addr;
  assign o_ram_cs         = r_ram_cs;
  assign o_ram_we         = r_ram_we;
  assign o_ram_oe         = r_ram_oe;
  assign s_bus.req_ready  = r_req_ready;
  assign s_bus.resp_valid = r_resp_valid;
  assign s_bus.resp_write = r_resp_write;
  assign s_bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural RAM array and reference memory.
module tb_ram_access_ctrl;
`ifdef RAM_TURNAROUND_EN
  localparam int RL     = 2;
  localparam int WR_LAT = 3;
`else
  localparam int RL     = 1;
  localparam int WR_LAT = 2;
`endif
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] ram_addr;
  wire  [DW-1:0] ram_data;
  logic          ram_cs, ram_we, ram_oe;

  ram_access_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .s_bus       (bus),
    .o_ram_addr  (ram_addr),
    .io_ram_data (ram_data),
    .o_ram_cs    (ram_cs),
    .o_ram_we    (ram_we),
    .o_ram_oe    (ram_oe)
  );

  // Physical array: drives the bus on cs+oe, commits on the edge ending a cs+we cycle.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  assign ram_data = (ram_cs && ram_oe && !ram_we) ? mem[ram_addr] : {DW{1'bz}};
  always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_data;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          we;
    logic [DW-1:0] rdata;
    int            lat;
    int            acc;
  } exp_t;
  exp_t sb[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int bp_mode = 0;
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       bus.resp_ready = 1'b1;
      1:       bus.resp_ready = ($urandom_range(0, 3) != 0);
      default: bus.resp_ready = 1'b0;
    endcase
  end

  // Monitor: pops expectations on the first cycle of each response, checks invariants.
  logic          holding = 1'b0, expect_idle = 1'b0, prev_we = 1'b0;
  logic          held_w;
  logic [DW-1:0] held_d;
  exp_t          me;
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0; expect_idle = 1'b0; prev_we = 1'b0;
    end else begin
      checks++;
      if ((ram_we && ram_oe) || ((ram_we || ram_oe) && !ram_cs)) begin
        errors++;
        $display("FAIL strobe_invariant: cs=%b we=%b oe=%b", ram_cs, ram_we, ram_oe);
      end
      if (prev_we) begin
        chk("post_write_cs", ram_cs, 0);
`ifdef RAM_TURNAROUND_EN
        chk("turnaround_resp_valid", bus.resp_valid, 0);
`endif
      end
      if (ram_cs || bus.resp_valid) chk("req_ready_busy", bus.req_ready, 0);
      if (expect_idle) begin
        chk("idle_req_ready", bus.req_ready, 1);
        chk("idle_resp_valid", bus.resp_valid, 0);
        expect_idle = 1'b0;
      end
      if (bus.resp_valid) begin
        if (!holding) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: write=%b rdata=0x%0h with empty scoreboard",
                     bus.resp_write, bus.resp_rdata);
          end else begin
            me = sb.pop_front();
            chk("resp_write", bus.resp_write, me.we);
            chk("resp_rdata", bus.resp_rdata, me.rdata);
            chk("resp_latency", cyc - me.acc + 1, me.lat);
          end
          holding = 1'b1;
          held_w  = bus.resp_write;
          held_d  = bus.resp_rdata;
        end else begin
          chk("hold_write", bus.resp_write, held_w);
          chk("hold_rdata", bus.resp_rdata, held_d);
        end
        if (bus.resp_ready) begin
          holding = 1'b0;
          expect_idle = 1'b1;
        end
      end
      prev_we = ram_we;
    end
  end

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = a; bus.req_wdata = d;
    n = 0;
    while (!bus.req_ready && n < 300) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
      bus.req_valid = 1'b0;
      return;
    end
    e.we    = we;
    e.acc   = cyc + 1;
    e.lat   = we ? WR_LAT : RL + 1;
    e.rdata = we ? '0 : ref_rd(a);
    if (we) ref_mem[a] = d;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    while ((sb.size() != 0 || bus.resp_valid) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_write"}, bus.resp_write, 0);
    chk({tag, "_resp_rdata"}, bus.resp_rdata, 0);
    chk({tag, "_ram_addr"}, ram_addr, 0);
    chk({tag, "_strobes"}, {ram_cs, ram_we, ram_oe}, 0);
  endtask

  logic [AW-1:0] pool [0:7];
  logic [AW-1:0] ra;
  logic          rwe;
  int            n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    pool[0] = 12'h000; pool[1] = 12'hFFF; pool[2] = 12'h3FF; pool[3] = 12'h400;
    pool[4] = 12'h7FF; pool[5] = 12'h800; pool[6] = 12'hBFF; pool[7] = 12'hC00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk); #1 rst = 1'b0;

    issue(1'b1, 12'h123, 16'h0ABC);
    issue(1'b0, 12'h123, 16'h0);
    drain();

    issue(1'b1, 12'h3FF, 16'h1111);
    issue(1'b1, 12'h400, 16'h2222);
    issue(1'b1, 12'h800, 16'h3333);
    issue(1'b1, 12'hC00, 16'h4444);
    issue(1'b0, 12'h3FF, 16'h0);
    issue(1'b0, 12'h400, 16'h0);
    issue(1'b0, 12'h800, 16'h0);
    issue(1'b0, 12'hC00, 16'h0);
    drain();

    // Backpressure with the next request already waiting.
    bp_mode = 2;
    issue(1'b0, 12'h800, 16'h0);
    fork
      issue(1'b1, 12'h555, 16'h5A5A);
      begin
        n = 0;
        while (!bus.resp_valid && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        chk("bp_valid_held", bus.resp_valid, 1);
        bp_mode = 0;
      end
    join
    drain();

    // Request held high throughout a read.
    issue(1'b0, 12'h555, 16'h0);
    issue(1'b1, 12'h556, 16'hBEEF);
    issue(1'b0, 12'h556, 16'h0);
    drain();

    // Reset during the first read cycle aborts without a response.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h123;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rst = 1'b1; bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midread_reset");
    @(posedge clk); #1 rst = 1'b0;
    issue(1'b0, 12'h123, 16'h0);
    drain();

    bp_mode = 1;
    for (int i = 0; i < 80; i++) begin
      ra  = ($urandom_range(0, 2) == 0) ? AW'($urandom) : pool[$urandom_range(0, 7)];
      rwe = ($urandom_range(0, 1) == 1) || !ref_mem.exists(ra);
      issue(rwe, ra, DW'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(negedge clk);
        bus.req_valid = 1'b0;
      end
    end
    drain();
    bp_mode = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
